mips_multicycle_core: RTL and testbench

//   Parametrised multi-cycle MIPS-subset core; successor to the single-cycle processor.

---
 rtl/mips_mc_pkg.sv | 62 ++++++
 rtl/mips_mc_regfile.sv | 28 ++
 rtl/mips_multicycle_core.sv | 196 +++++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core.
// Covers opcode/funct encodings, FSM states, the internal ALU op encoding and instruction classes.
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BGTZ  = 6'h07;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL} alu_op_t;

  typedef enum logic [2:0] {
    CLS_RTYPE, CLS_ADDI, CLS_LW, CLS_SW, CLS_BRANCH, CLS_ILLEGAL
  } instr_class_t;

  function automatic instr_class_t decode_class(input logic [5:0] opcode, input logic [5:0] funct);
    instr_class_t cls;
    cls = CLS_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_SLT: cls = CLS_RTYPE;
          default: cls = CLS_ILLEGAL;
        endcase
      end
      OP_ADDI: cls = CLS_ADDI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ, OP_BNE, OP_BGTZ: cls = CLS_BRANCH;
      default: cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  function automatic alu_op_t funct_to_alu(input logic [5:0] funct);
    alu_op_t op;
    case (funct)
      FN_SUB, FN_SUBU: op = ALU_SUB;
      FN_AND:          op = ALU_AND;
      FN_OR:           op = ALU_OR;
      FN_SLT:          op = ALU_SLT;
      FN_SLL:          op = ALU_SLL;
      default:         op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// Register $0 ignores writes and always reads as zero.
module mips_mc_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core over one req/ack memory port, with halt and misalignment reporting.
// Optional cycle/instruction counters are enabled with the MIPS_MC_PERF_CNT_EN macro.
module mips_multicycle_core
  import mips_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       pc_out,
  output logic              instr_retired,
  output logic              halted,
  output logic              err_misalign
`ifdef MIPS_MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instr_cnt
`endif
);

  state_t       state, state_nxt;
  instr_class_t cls;
  alu_op_t      alu_op;

  logic        run;
  logic [31:0] pc, ir, a_reg, b_reg, alu_out, mdr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] simm, alu_b, alu_res, pc_plus4, pc_branch;
  logic [31:0] rf_rd1, rf_rd2, rf_wd;
  logic [4:0]  rf_wa;
  logic        rf_we, taken, misalign;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];
  assign simm   = {{16{ir[15]}}, ir[15:0]};

  assign cls       = decode_class(opcode, funct);
  assign alu_op    = (cls == CLS_RTYPE) ? funct_to_alu(funct) : ALU_ADD;
  assign alu_b     = (cls == CLS_RTYPE) ? b_reg : simm;
  assign pc_plus4  = pc + 32'd4;
  assign pc_branch = pc_plus4 + {simm[29:0], 2'b00};
  assign misalign  = (alu_res[1:0] != 2'b00);

  always_comb begin
    alu_res = a_reg + alu_b;
    case (alu_op)
      ALU_SUB: alu_res = a_reg - alu_b;
      ALU_AND: alu_res = a_reg & alu_b;
      ALU_OR:  alu_res = a_reg | alu_b;
      ALU_SLT: alu_res = {31'd0, $signed(a_reg) < $signed(alu_b)};
      ALU_SLL: alu_res = b_reg << shamt;
      default: alu_res = a_reg + alu_b;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BEQ:  taken = (a_reg == b_reg);
      OP_BNE:  taken = (a_reg != b_reg);
      OP_BGTZ: taken = ($signed(a_reg) > 32'sd0);
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // run stays low for the first cycle after reset so no request is issued in that cycle
  always_comb begin
    state_nxt     = state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = pc[ADDR_W-1:0];
    instr_retired = 1'b0;
    case (state)
      FETCH: begin
        mem_req = run;
        if (run && mem_ack) state_nxt = DECODE;
      end
      DECODE: state_nxt = (cls == CLS_ILLEGAL) ? HALT : EXEC;
      EXEC: begin
        case (cls)
          CLS_BRANCH: begin
            instr_retired = 1'b1;
            state_nxt     = FETCH;
          end
          CLS_LW, CLS_SW: state_nxt = misalign ? HALT : MEM;
          default:        state_nxt = WB;
        endcase
      end
      MEM: begin
        mem_req  = 1'b1;
        mem_we   = (cls == CLS_SW);
        mem_addr = alu_out[ADDR_W-1:0];
        if (mem_ack) begin
          if (cls == CLS_SW) begin
            instr_retired = 1'b1;
            state_nxt     = FETCH;
          end else begin
            state_nxt = WB;
          end
        end
      end
      WB: begin
        instr_retired = 1'b1;
        state_nxt     = FETCH;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run          <= 1'b0;
      pc           <= RESET_PC;
      ir           <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      alu_out      <= '0;
      mdr          <= '0;
      err_misalign <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        FETCH:  if (run && mem_ack) ir <= mem_rdata;
        DECODE: begin
          a_reg <= rf_rd1;
          b_reg <= rf_rd2;
        end
        EXEC: begin
          alu_out <= alu_res;
          if (cls == CLS_BRANCH) pc <= taken ? pc_branch : pc_plus4;
          if ((cls == CLS_LW || cls == CLS_SW) && misalign) err_misalign <= 1'b1;
        end
        MEM: begin
          if (mem_ack) begin
            if (cls == CLS_LW) mdr <= mem_rdata;
            else               pc  <= pc_plus4;
          end
        end
        WB:      pc <= pc_plus4;
        default: ;
      endcase
    end
  end

  assign rf_we = (state == WB);
  assign rf_wa = (cls == CLS_RTYPE) ? rd : rt;
  assign rf_wd = (cls == CLS_LW) ? mdr : alu_out;

  mips_mc_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2),
    .we    (rf_we),
    .wa    (rf_wa),
    .wd    (rf_wd)
  );

  assign mem_wdata = b_reg;
  assign pc_out    = pc;
  assign halted    = (state == HALT);

`ifdef MIPS_MC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (state != HALT) begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (instr_retired) instr_cnt <= instr_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Testbench for mips_multicycle_core: directed programs plus random programs against an ISA-level model.
// Builds with or without MIPS_MC_PERF_CNT_EN.
module tb_mips_multicycle_core;

  localparam logic [31:0] DATA_BASE = 32'h200;
  localparam logic [5:0]  OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0]  OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BGTZ = 6'h07;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ack, instr_retired, halted, err_misalign;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
`ifdef MIPS_MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] ref_regs [32];
  logic [31:0] ref_pc, prog_end;

  int checks = 0, failures = 0;
  int waits_seen = 0, last_cyc = 0, total_cyc = 0;
  int fetch_delay = 0, data_delay = 0;
  bit rand_delay = 0;
  logic [31:0] pc_log [$];
  logic [31:0] perf_cyc, perf_ins;

  always #5 clk = ~clk;

  mips_multicycle_core dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .pc_out        (pc_out),
    .instr_retired (instr_retired),
    .halted        (halted),
    .err_misalign  (err_misalign)
`ifdef MIPS_MC_PERF_CNT_EN
    ,
    .cycle_cnt     (cycle_cnt),
    .instr_cnt     (instr_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst);
    @(posedge clk);
    #1 reset = rst;
  endtask

  // Memory responder: per-request wait, address/data stability while waiting
  initial begin : responder
    bit          busy;
    int          waited, cur_delay;
    logic [31:0] cap_addr, cap_wd;
    logic        cap_we;
    busy = 0; waited = 0; cur_delay = 0;
    cap_addr = '0; cap_wd = '0; cap_we = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      mem_ack = 1'b0;
      if (reset || !mem_req) begin
        busy = 0;
      end else begin
        if (!busy) begin
          busy = 1; waited = 0;
          cap_addr = mem_addr; cap_we = mem_we; cap_wd = mem_wdata;
          if (rand_delay)              cur_delay = $urandom_range(0, 2);
          else if (mem_addr >= DATA_BASE) cur_delay = data_delay;
          else                         cur_delay = fetch_delay;
        end else begin
          checkOutput("req_addr_stable", mem_addr, cap_addr);
          checkOutput("req_we_stable", {31'd0, mem_we}, {31'd0, cap_we});
          if (cap_we) checkOutput("req_wdata_stable", mem_wdata, cap_wd);
        end
        if (waited == cur_delay) begin
          mem_ack = 1'b1;
          if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
          else        mem_rdata = mem[mem_addr[9:2]];
          busy = 0;
        end else begin
          waited++;
          waits_seen++;
        end
      end
    end
  end

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh,
                                        input logic [5:0] fn);
    logic [31:0] a, b, c, d;
    a = rs; b = rt; c = rd; d = sh;
    return {6'h00, a[4:0], b[4:0], c[4:0], d[4:0], fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    logic [31:0] a, b;
    a = rs; b = rt;
    return {op, a[4:0], b[4:0], imm};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    for (int i = 0; i < 32; i++) ref_regs[i] = '0;
    ref_pc = '0;
    pc_log.delete();
    total_cyc = 0;
  endtask

  task automatic load(input int idx, input logic [31:0] w);
    mem[idx] = w;
    ref_mem[idx] = w;
  endtask

  task automatic wr(input int r, input logic [31:0] v);
    if (r != 0) ref_regs[r] = v;
  endtask

  // ISA-level model: executes one instruction, returns zero-wait cycle count
  task automatic ref_step(output int base, output bit halt, output bit mis);
    logic [31:0] ins, a, b, simm, addr, res;
    int rs, rt, rd, sh;
    bit tk;
    ins = ref_mem[ref_pc[9:2]];
    rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]); sh = int'(ins[10:6]);
    simm = {{16{ins[15]}}, ins[15:0]};
    a = ref_regs[rs]; b = ref_regs[rt];
    halt = 0; mis = 0; base = 4; res = '0; tk = 0;
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h20, 6'h21: res = a + b;
          6'h22, 6'h23: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h00: res = b << sh;
          default: halt = 1;
        endcase
        if (!halt) begin wr(rd, res); ref_pc = ref_pc + 4; end
      end
      OP_ADDI: begin wr(rt, a + simm); ref_pc = ref_pc + 4; end
      OP_LW, OP_SW: begin
        addr = a + simm;
        if (addr[1:0] != 2'b00) begin
          halt = 1; mis = 1;
        end else if (ins[31:26] == OP_LW) begin
          wr(rt, ref_mem[addr[9:2]]); base = 5; ref_pc = ref_pc + 4;
        end else begin
          ref_mem[addr[9:2]] = b; ref_pc = ref_pc + 4;
        end
      end
      OP_BEQ, OP_BNE, OP_BGTZ: begin
        base = 3;
        if (ins[31:26] == OP_BEQ)      tk = (a == b);
        else if (ins[31:26] == OP_BNE) tk = (a != b);
        else                           tk = ($signed(a) > 0);
        ref_pc = tk ? ref_pc + 4 + (simm << 2) : ref_pc + 4;
      end
      default: halt = 1;
    endcase
  endtask

  task automatic exec_one(input logic [31:0] exp_pc, input int base);
    int cyc, w0;
    bit started, done;
    cyc = 0; w0 = waits_seen; started = 0; done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      #2;
      if (mem_req) started = 1;
      if (started) cyc++;
      if (instr_retired) done = 1;
    end
    checkOutput("retire_seen", {31'd0, done}, 32'd1);
    checkOutput("pc_at_retire", pc_out, exp_pc);
    checkOutput("instr_cycles", cyc, base + (waits_seen - w0));
    last_cyc = cyc;
    total_cyc += cyc;
    pc_log.push_back(pc_out);
`ifdef MIPS_MC_PERF_CNT_EN
    perf_cyc = cycle_cnt;
    perf_ins = instr_cnt;
`endif
  endtask

  task automatic check_halt(input logic [31:0] exp_pc, input bit mis);
    bit saw_ret, saw_halt;
    saw_ret = 0; saw_halt = 0;
    for (int k = 0; k < 60 && !saw_halt; k++) begin
      @(negedge clk);
      #2;
      if (instr_retired) saw_ret = 1;
      if (halted) saw_halt = 1;
    end
    checkOutput("halted", {31'd0, halted}, 32'd1);
    checkOutput("err_misalign", {31'd0, err_misalign}, {31'd0, mis});
    checkOutput("halt_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("halt_pc", pc_out, exp_pc);
`ifdef MIPS_MC_PERF_CNT_EN
    perf_cyc = cycle_cnt;
    perf_ins = instr_cnt;
`endif
    repeat (3) begin
      @(negedge clk);
      #2;
      if (instr_retired) saw_ret = 1;
    end
    checkOutput("halt_sticky", {31'd0, halted}, 32'd1);
    checkOutput("halt_req_still_low", {31'd0, mem_req}, 32'd0);
    checkOutput("halt_pc_frozen", pc_out, exp_pc);
    checkOutput("halt_no_retire", {31'd0, saw_ret}, 32'd0);
`ifdef MIPS_MC_PERF_CNT_EN
    checkOutput("halt_cycle_cnt_frozen", cycle_cnt, perf_cyc);
    checkOutput("halt_instr_cnt_frozen", instr_cnt, perf_ins);
`endif
  endtask

  task automatic run_program(input int max_instr);
    int base;
    bit halt, mis;
    logic [31:0] old_pc;
    for (int n = 0; n < max_instr && ref_pc < prog_end; n++) begin
      old_pc = ref_pc;
      ref_step(base, halt, mis);
      if (halt) begin
        check_halt(old_pc, mis);
        break;
      end
      exec_one(old_pc, base);
    end
  endtask

  task automatic check_data();
    for (int i = 128; i < 160; i++)
      checkOutput($sformatf("mem[%0h]", i * 4), mem[i], ref_mem[i]);
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    #2;
    checkOutput("rst_pc", pc_out, 32'h0);
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_retired", {31'd0, instr_retired}, 32'd0);
    checkOutput("rst_halted", {31'd0, halted}, 32'd0);
    checkOutput("rst_misalign", {31'd0, err_misalign}, 32'd0);
`ifdef MIPS_MC_PERF_CNT_EN
    checkOutput("rst_cycle_cnt", cycle_cnt, 32'd0);
    checkOutput("rst_instr_cnt", instr_cnt, 32'd0);
`endif
  endtask

  task automatic gen_random_program();
    logic [5:0] fns [8];
    logic [5:0] bop;
    int L, kind, off;
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00};
    L = 20;
    for (int i = 0; i < L; i++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: load(i, enc_i(OP_ADDI, $urandom_range(0, 7), $urandom_range(1, 7), 16'($urandom)));
        1: load(i, enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom_range(0, 31), fns[$urandom_range(0, 7)]));
        2: load(i, enc_i(OP_LW, 0, $urandom_range(1, 7), 16'(32'h200 + 4 * $urandom_range(0, 15))));
        3: load(i, enc_i(OP_SW, 0, $urandom_range(0, 7), 16'(32'h200 + 4 * $urandom_range(0, 15))));
        default: begin
          kind = $urandom_range(0, 2);
          bop = (kind == 0) ? OP_BEQ : (kind == 1) ? OP_BNE : OP_BGTZ;
          off = $urandom_range(0, L - 1 - i);
          load(i, enc_i(bop, $urandom_range(0, 7), (bop == OP_BGTZ) ? 0 : $urandom_range(0, 7), 16'(off)));
        end
      endcase
    end
    for (int r = 1; r < 8; r++) load(L - 1 + r, enc_i(OP_SW, 0, r, 16'(32'h240 + 4 * r)));
    for (int i = 128; i < 144; i++) load(i, $urandom);
    prog_end = 32'((L + 7) * 4);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    logic [31:0] exp_pcs [7];
    exp_pcs = '{32'h00, 32'h04, 32'h08, 32'h14, 32'h18, 32'h1C, 32'h24};
    perf_cyc = '0;
    perf_ins = '0;

    // Straight-line program, zero-wait memory
    applyStimulus(1);
    clear_mem();
    load(0, enc_i(OP_ADDI, 0, 1, 16'd5));
    load(1, enc_i(OP_ADDI, 0, 2, 16'd7));
    load(2, enc_r(1, 2, 3, 0, 6'h20));
    load(3, enc_i(OP_SW, 0, 3, 16'h0040));
    prog_end = 32'h10;
    applyStimulus(0);
    check_reset_state();
    run_program(10);
    checkOutput("t1_mem40", mem[16], 32'd12);
    checkOutput("t1_retires", pc_log.size(), 32'd4);
    checkOutput("t1_total_cycles", total_cyc, 32'd16);
`ifdef MIPS_MC_PERF_CNT_EN
    checkOutput("t1_cycle_cnt", perf_cyc, 32'd16);
    checkOutput("t1_instr_cnt", perf_ins, 32'd3);
`endif

    // lw with a three-cycle data wait
    applyStimulus(1);
    clear_mem();
    data_delay = 3;
    load(128, 32'hCAFE_F00D);
    load(0, enc_i(OP_LW, 0, 5, 16'h0200));
    load(1, enc_i(OP_SW, 0, 5, 16'h0204));
    prog_end = 32'h8;
    applyStimulus(0);
    run_program(1);
    checkOutput("t2_lw_cycles", last_cyc, 32'd8);
    run_program(1);
    checkOutput("t2_lw_data", mem[129], 32'hCAFE_F00D);
    data_delay = 0;

    // Branches
    applyStimulus(1);
    clear_mem();
    load(128, 32'hDEAD_BEEF);
    load(0, enc_i(OP_ADDI, 0, 1, 16'hFFFF));
    load(1, enc_i(OP_ADDI, 0, 2, 16'd1));
    load(2, enc_i(OP_BEQ, 0, 0, 16'd2));
    load(3, enc_i(OP_ADDI, 0, 3, 16'd99));
    load(4, enc_i(OP_ADDI, 0, 3, 16'd98));
    load(5, enc_i(OP_BNE, 1, 1, 16'd5));
    load(6, enc_i(OP_BGTZ, 1, 0, 16'd5));
    load(7, enc_i(OP_BGTZ, 2, 0, 16'd1));
    load(8, enc_i(OP_ADDI, 0, 3, 16'd77));
    load(9, enc_i(OP_SW, 0, 3, 16'h0200));
    prog_end = 32'h28;
    applyStimulus(0);
    run_program(20);
    checkOutput("t3_retires", pc_log.size(), 32'd7);
    for (int i = 0; i < 7 && i < pc_log.size(); i++)
      checkOutput($sformatf("t3_pc_seq%0d", i), pc_log[i], exp_pcs[i]);
    checkOutput("t3_skipped_store", mem[128], 32'd0);

    // $0 behaviour and wrap-around arithmetic
    applyStimulus(1);
    clear_mem();
    load(129, 32'h5555_5555);
    load(132, 32'h1234_5678);
    load(0, enc_i(OP_ADDI, 0, 0, 16'd9));
    load(1, enc_r(0, 0, 4, 0, 6'h20));
    load(2, enc_i(OP_SW, 0, 4, 16'h0204));
    load(3, enc_i(OP_ADDI, 0, 5, 16'd1));
    load(4, enc_r(0, 5, 5, 31, 6'h00));
    load(5, enc_i(OP_ADDI, 5, 5, 16'hFFFF));
    load(6, enc_i(OP_ADDI, 5, 6, 16'd1));
    load(7, enc_i(OP_SW, 0, 6, 16'h0208));
    load(8, enc_i(OP_SW, 0, 5, 16'h020C));
    load(9, enc_i(OP_SW, 0, 0, 16'h0210));
    prog_end = 32'h28;
    applyStimulus(0);
    run_program(20);
    checkOutput("t4_reg4_zero", mem[129], 32'd0);
    checkOutput("t4_wrap", mem[130], 32'h8000_0000);
    checkOutput("t4_max_pos", mem[131], 32'h7FFF_FFFF);
    checkOutput("t4_reg0_zero", mem[132], 32'd0);

    // Misaligned lw
    applyStimulus(1);
    clear_mem();
    load(0, enc_i(OP_ADDI, 0, 1, 16'd3));
    load(1, enc_i(OP_LW, 0, 2, 16'h0042));
    prog_end = 32'h8;
    applyStimulus(0);
    run_program(5);
    checkOutput("t5_misalign_flag", {31'd0, err_misalign}, 32'd1);

    // Illegal opcode
    applyStimulus(1);
    clear_mem();
    load(0, enc_i(OP_ADDI, 0, 1, 16'd3));
    load(1, 32'hFC00_0000);
    prog_end = 32'h8;
    applyStimulus(0);
    check_reset_state();
    run_program(5);
    checkOutput("t5_illegal_no_misalign", {31'd0, err_misalign}, 32'd0);

    // Reset during a waiting fetch
    applyStimulus(1);
    clear_mem();
    load(0, enc_i(OP_ADDI, 0, 1, 16'd1));
    load(1, enc_i(OP_ADDI, 0, 2, 16'd2));
    prog_end = 32'h8;
    applyStimulus(0);
    run_program(1);
    fetch_delay = 20;
    repeat (3) begin @(negedge clk); #2; end
    checkOutput("t6_waiting_req", {31'd0, mem_req}, 32'd1);
    checkOutput("t6_waiting_pc", pc_out, 32'h4);
    applyStimulus(1);
    clear_mem();
    applyStimulus(0);
    check_reset_state();
    fetch_delay = 0;

    // Random programs with random wait states
    rand_delay = 1;
    for (int p = 0; p < 3; p++) begin
      applyStimulus(1);
      clear_mem();
      gen_random_program();
      applyStimulus(0);
      run_program(200);
      checkOutput($sformatf("rand%0d_done", p), {31'd0, ref_pc >= prog_end}, 32'd1);
      check_data();
    end
    rand_delay = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
